// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - plays a table of timed register writes to an LED controller
module led_pattern_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter int ADDR_BITS  = 4,
  parameter int DEPTH      = 8,
  parameter int DELAY_BITS = 16
) (
  input  logic                     clk_400K,
  input  logic                     reset_n,
  input  logic                     sleep,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_idx,
  input  logic [ADDR_BITS-1:0]     ld_addr,
  input  logic [DATA_BITS-1:0]     ld_data,
  input  logic [DELAY_BITS-1:0]    ld_delay,
  input  logic [$clog2(DEPTH)-1:0] len,
  input  logic                     loop,
  input  logic                     start,
  input  logic                     stop,
  output logic [ADDR_BITS-1:0]     bus_addr,
  output logic [DATA_BITS-1:0]     bus_wdata,
  output logic                     bus_w_en,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] step,
  output logic                     done
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]            state;
  logic [DELAY_BITS-1:0] cnt;

  logic [ADDR_BITS-1:0]  tbl_addr  [DEPTH];
  logic [DATA_BITS-1:0]  tbl_data  [DEPTH];
  logic [DELAY_BITS-1:0] tbl_delay [DEPTH];

  logic [DELAY_BITS-1:0] cur_delay;
  logic [IW-1:0]         nxt_step;
  logic                  finish;
  logic                  adv;

  // The table is frozen while a sequence plays, so the current entry's delay can be read live
  assign cur_delay = tbl_delay[step];

  // Next-step decision: len and loop are sampled whenever an entry finishes
  always_comb begin
    finish   = 1'b0;
    nxt_step = step + 1'b1;
    if (step == len) begin
      nxt_step = '0;
      finish   = !loop;
    end
  end

  // Entry finished: straight after WRITE for zero delay, else on the last WAIT cycle
  always_comb begin
    adv = 1'b0;
    if (!stop) begin
      if (state == S_WRITE && cur_delay == '0) adv = 1'b1;
      if (state == S_WAIT && !sleep && cnt == '0) adv = 1'b1;
    end
  end

  // Pattern table, writable only while no sequence is running
  always_ff @(posedge clk_400K or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_addr[i]  <= '0;
        tbl_data[i]  <= '0;
        tbl_delay[i] <= '0;
      end
    end else if (ld_en && !busy) begin
      tbl_addr[ld_idx]  <= ld_addr;
      tbl_data[ld_idx]  <= ld_data;
      tbl_delay[ld_idx] <= ld_delay;
    end
  end

  // Sequencer FSM; bus address/data are loaded on entry to SETUP and held through WRITE and IDLE
  always_ff @(posedge clk_400K or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_w_en  <= 1'b0;
      busy      <= 1'b0;
      step      <= '0;
      done      <= 1'b0;
    end else begin
      bus_w_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop && !sleep) begin
            state     <= S_SETUP;
            step      <= '0;
            busy      <= 1'b1;
            bus_addr  <= tbl_addr[0];
            bus_wdata <= tbl_data[0];
          end
        end
        S_SETUP: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (!sleep) begin
            state    <= S_WRITE;
            bus_w_en <= 1'b1;
          end
        end
        S_WRITE: begin
          // The write strobe has already been issued, so stop or sleep cannot cut it short
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (cur_delay != '0) begin
            state <= S_WAIT;
            cnt   <= cur_delay - 1'b1;
          end
        end
        S_WAIT: begin
          if (stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (!sleep && cnt != '0) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (adv) begin
        if (finish) begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state     <= S_SETUP;
          step      <= nxt_step;
          bus_addr  <= tbl_addr[nxt_step];
          bus_wdata <= tbl_data[nxt_step];
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - directed self-checking bench for led_pattern_sequencer
`timescale 1ns/1ps
module tb_led_pattern_sequencer;

  localparam int DB  = 8;
  localparam int AB  = 4;
  localparam int DP  = 8;
  localparam int DLB = 16;
  localparam int IW  = 3;

  localparam logic [AB-1:0] PWM0   = 4'h2;
  localparam logic [AB-1:0] PWM1   = 4'h3;
  localparam logic [AB-1:0] GRPPWM = 4'h6;
  localparam logic [AB-1:0] LEDOUT = 4'h8;

  logic           clk_400K = 1'b0;
  logic           reset_n  = 1'b0;
  logic           sleep    = 1'b0;
  logic           ld_en    = 1'b0;
  logic [IW-1:0]  ld_idx   = '0;
  logic [AB-1:0]  ld_addr  = '0;
  logic [DB-1:0]  ld_data  = '0;
  logic [DLB-1:0] ld_delay = '0;
  logic [IW-1:0]  len      = '0;
  logic           loop     = 1'b0;
  logic           start    = 1'b0;
  logic           stop     = 1'b0;
  logic [AB-1:0]  bus_addr;
  logic [DB-1:0]  bus_wdata;
  logic           bus_w_en;
  logic           busy;
  logic [IW-1:0]  step;
  logic           done;

  int total = 0;
  int bad   = 0;

  led_pattern_sequencer #(
    .DATA_BITS(DB), .ADDR_BITS(AB), .DEPTH(DP), .DELAY_BITS(DLB)
  ) dut (
    .clk_400K(clk_400K), .reset_n(reset_n), .sleep(sleep), .ld_en(ld_en),
    .ld_idx(ld_idx), .ld_addr(ld_addr), .ld_data(ld_data), .ld_delay(ld_delay),
    .len(len), .loop(loop), .start(start), .stop(stop),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_w_en(bus_w_en),
    .busy(busy), .step(step), .done(done)
  );

  always #5 clk_400K = ~clk_400K;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_400K);
    #1;
  endtask

  task automatic load(input logic [IW-1:0] i, input logic [AB-1:0] a,
                      input logic [DB-1:0] d, input logic [DLB-1:0] dl);
    ld_en = 1'b1; ld_idx = i; ld_addr = a; ld_data = d; ld_delay = dl;
    tick();
    ld_en = 1'b0;
  endtask

  // Three-entry run: writes at cycles 2, 4 and w3; done one cycle after w3
  task automatic run_std(input int w3, input int slp_on, input int slp_off, input bit poke);
    len = 3'd2; loop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= w3 + 2; c++) begin
      logic we;
      logic [IW-1:0] es;
      we = (c == 2) || (c == 4) || (c == w3);
      es = (c < 3) ? 3'd0 : ((c < w3 - 1) ? 3'd1 : 3'd2);
      chk($sformatf("w_en c%0d", c), 32'(bus_w_en), 32'(we));
      chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= w3));
      chk($sformatf("done c%0d", c), 32'(done), 32'(c == w3 + 1));
      chk($sformatf("step c%0d", c), 32'(step), 32'(es));
      if (c == 2) begin
        chk("addr e0", 32'(bus_addr), 32'(LEDOUT));
        chk("data e0", 32'(bus_wdata), 32'h55);
      end
      if (c == 4) begin
        chk("addr e1", 32'(bus_addr), 32'(PWM0));
        chk("data e1", 32'(bus_wdata), 32'h40);
      end
      if (c == w3) begin
        chk("addr e2", 32'(bus_addr), 32'(GRPPWM));
        chk("data e2", 32'(bus_wdata), 32'hC0);
      end
      if (c == slp_on) sleep = 1'b1;
      if (c == slp_off) sleep = 1'b0;
      if (poke && c == 5) begin
        ld_en = 1'b1; ld_idx = 3'd1; ld_addr = PWM0; ld_data = 8'hFF; ld_delay = 16'd4;
      end
      if (poke && c == 6) ld_en = 1'b0;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst bus_addr", 32'(bus_addr), 32'h0);
    chk("rst bus_wdata", 32'(bus_wdata), 32'h0);
    chk("rst w_en", 32'(bus_w_en), 32'h0);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst step", 32'(step), 32'h0);
    chk("rst done", 32'(done), 32'h0);
    reset_n = 1'b1;
    tick();

    // Basic three-entry run, with a load attempt while busy
    load(3'd0, LEDOUT, 8'h55, 16'd0);
    load(3'd1, PWM0, 8'h40, 16'd4);
    load(3'd2, GRPPWM, 8'hC0, 16'd0);
    run_std(10, -1, -1, 1'b1);
    tick();

    // Same run, entry 1 must still hold 0x40; sleep 10 cycles in its WAIT
    run_std(20, 6, 16, 1'b0);
    tick();

    // Single looping entry, stopped during WAIT
    load(3'd0, PWM1, 8'h80, 16'd2);
    len = 3'd0; loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      logic we;
      we = (c >= 2) && (((c - 2) % 4) == 0);
      chk($sformatf("loop w_en c%0d", c), 32'(bus_w_en), 32'(we));
      if (we) begin
        chk($sformatf("loop addr c%0d", c), 32'(bus_addr), 32'(PWM1));
        chk($sformatf("loop data c%0d", c), 32'(bus_wdata), 32'h80);
      end
      if (c == 15) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    for (int c = 16; c <= 23; c++) begin
      chk($sformatf("stopped w_en c%0d", c), 32'(bus_w_en), 32'h0);
      chk($sformatf("stopped done c%0d", c), 32'(done), 32'h0);
      chk($sformatf("stopped busy c%0d", c), 32'(busy), 32'h0);
      tick();
    end

    // Start and stop together in IDLE
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("ss busy c%0d", c), 32'(busy), 32'h0);
      chk($sformatf("ss w_en c%0d", c), 32'(bus_w_en), 32'h0);
      tick();
    end

    // Asynchronous reset during WAIT, then replay of a zeroed table
    load(3'd0, LEDOUT, 8'h55, 16'd0);
    len = 3'd2; loop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    chk("pre-rst busy", 32'(busy), 32'h1);
    chk("pre-rst addr", 32'(bus_addr), 32'(PWM0));
    #2 reset_n = 1'b0;
    #1;
    chk("async busy", 32'(busy), 32'h0);
    chk("async step", 32'(step), 32'h0);
    chk("async addr", 32'(bus_addr), 32'h0);
    chk("async data", 32'(bus_wdata), 32'h0);
    chk("async w_en", 32'(bus_w_en), 32'h0);
    chk("async done", 32'(done), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("post-rst idle", 32'(busy), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      logic we;
      we = (c == 2) || (c == 4) || (c == 6);
      chk($sformatf("zero w_en c%0d", c), 32'(bus_w_en), 32'(we));
      chk($sformatf("zero done c%0d", c), 32'(done), 32'(c == 7));
      if (we) begin
        chk($sformatf("zero addr c%0d", c), 32'(bus_addr), 32'h0);
        chk($sformatf("zero data c%0d", c), 32'(bus_wdata), 32'h0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
